tick_scheduler: RTL and testbench

- Shares one free-running prescaler (the base clock divider) among NUM_CH independent channels.
- Each channel has a runtime-programmable period and produces a one-cycle tick pulse plus a 50%-duty toggled output.
- A valid/ready config port lets a host enable, disable or retime channels. Period changes are applied glitch-free at channel boundaries.
- Sits between system control logic and timer/LED/PWM consumers that need slow enables from the fast system clock.

---
 rtl/tick_sched_pkg.sv | 21 ++
 rtl/tick_scheduler_if.sv | 27 ++
 rtl/tick_channel.sv | 68 ++++++
 rtl/tick_scheduler.sv | 150 +++++++++++++++
 tb/tb_tick_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and elaboration-time helpers for the tick scheduler.
package tick_sched_pkg;

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  // Clamped to 1 so a mis-set TICK_FREQ can never yield a zero-length prescaler.
  function automatic int unsigned calc_prescale(input int unsigned freq_in,
                                                input int unsigned tick_freq);
    int unsigned ps;
    ps = (tick_freq == 0) ? 1 : freq_in / tick_freq;
    return (ps == 0) ? 1 : ps;
  endfunction

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Config port of the tick scheduler: host drives requests, scheduler answers ready/err.
interface tick_scheduler_if
  import tick_sched_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PERIOD_W = 16
);
  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic                cfg_enable;
  logic [PERIOD_W-1:0] cfg_period;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_enable, cfg_period,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_enable, cfg_period,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/tick_channel.sv
// One scheduler channel: period counter, registered tick and toggled output.
// Optional TICK_SCHED_SYNC_EN adds a sync_clr input that realigns the channel.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                base_tick,
  input  logic                load_now,
  input  logic                new_enable,
  input  logic                load_at_wrap,
  input  logic [PERIOD_W-1:0] new_period,
`ifdef TICK_SCHED_SYNC_EN
  input  logic                sync_clr,
`endif
  output logic                wrap,
  output logic                active,
  output logic                tick,
  output logic                out
);

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;
  logic                en;

  assign active = en;
  assign wrap   = en && base_tick && (cnt == period - PERIOD_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      period <= '0;
      cnt    <= '0;
      en     <= 1'b0;
      out    <= 1'b0;
      tick   <= 1'b0;
    end else if (load_now) begin
      // A zero period is indistinguishable from a disable request.
      en     <= new_enable && (new_period != '0);
      period <= new_period;
      cnt    <= '0;
      out    <= 1'b0;
      tick   <= 1'b0;
`ifdef TICK_SCHED_SYNC_EN
    end else if (sync_clr) begin
      cnt  <= '0;
      out  <= 1'b0;
      tick <= 1'b0;
      if (load_at_wrap) begin
        period <= new_period;
      end
`endif
    end else begin
      tick <= wrap;
      if (wrap) begin
        cnt <= '0;
        out <= ~out;
        if (load_at_wrap) begin
          period <= new_period;
        end
      end else if (en && base_tick) begin
        cnt <= cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler plus NUM_CH programmable tick channels behind a valid/ready config port.
// Optional TICK_SCHED_SYNC_EN adds sync_req to realign prescaler and all channels.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned FREQ_IN   = 1_000_000,
  parameter int unsigned TICK_FREQ = 1_000,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PERIOD_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
`ifdef TICK_SCHED_SYNC_EN
  input  logic               sync_req,
`endif
  tick_scheduler_if.slave    cfg,
  output logic               base_tick,
  output logic [NUM_CH-1:0]  ch_tick,
  output logic [NUM_CH-1:0]  ch_out,
  output logic [NUM_CH-1:0]  ch_busy
);

  localparam int unsigned PRESCALE = calc_prescale(FREQ_IN, TICK_FREQ);
  localparam int unsigned CH_W     = ch_idx_w(NUM_CH);
  localparam int unsigned IDX_N    = 1 << CH_W;
  localparam logic [31:0] PS_LAST  = 32'(PRESCALE - 1);

  logic [31:0]         ps_cnt;
  state_t              state, state_nxt;
  logic [CH_W-1:0]     pend_ch, pend_ch_nxt;
  logic [PERIOD_W-1:0] pend_period, pend_period_nxt;
  logic [PERIOD_W-1:0] new_period;
  logic [CH_W-1:0]     sel_ch;
  logic                xfer;
  logic                err_q, err_nxt;

  logic [NUM_CH-1:0]   wrap_v, active_v;
  logic [IDX_N-1:0]    wrap_pad, active_pad, load_pad, busy_pad, ch_ok;

  assign sel_ch     = cfg.cfg_ch;
  assign wrap_pad   = IDX_N'(wrap_v);
  assign active_pad = IDX_N'(active_v);

  // Indices that encode past NUM_CH are flagged as errors instead of aliasing a channel.
  always_comb begin
    ch_ok = '0;
    for (int unsigned i = 0; i < IDX_N; i++) begin
      ch_ok[i] = (i < NUM_CH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt <= '0;
`ifdef TICK_SCHED_SYNC_EN
    end else if (sync_req) begin
      ps_cnt <= '0;
`endif
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 32'd1;
    end
  end

  assign base_tick = (ps_cnt == PS_LAST);

  assign xfer          = cfg.cfg_valid && (state == S_IDLE);
  assign cfg.cfg_ready = (state == S_IDLE);
  assign cfg.cfg_err   = err_q;
  assign new_period    = (state == S_HOLD) ? pend_period : cfg.cfg_period;

  always_comb begin
    state_nxt       = state;
    pend_ch_nxt     = pend_ch;
    pend_period_nxt = pend_period;
    load_pad        = '0;
    err_nxt         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (xfer) begin
          if (!ch_ok[sel_ch]) begin
            err_nxt = 1'b1;
          end else if (cfg.cfg_enable && (cfg.cfg_period != '0) && active_pad[sel_ch]) begin
            state_nxt       = S_HOLD;
            pend_ch_nxt     = sel_ch;
            pend_period_nxt = cfg.cfg_period;
          end else begin
            load_pad[sel_ch] = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (wrap_pad[pend_ch]) begin
          state_nxt = S_IDLE;
        end
      end
    endcase
`ifdef TICK_SCHED_SYNC_EN
    // The pending channel takes its new period on the sync edge itself.
    if (sync_req && (state == S_HOLD)) begin
      state_nxt = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pend_ch     <= '0;
      pend_period <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend_ch     <= pend_ch_nxt;
      pend_period <= pend_period_nxt;
      err_q       <= err_nxt;
    end
  end

  always_comb begin
    busy_pad = '0;
    if (state == S_HOLD) begin
      busy_pad[pend_ch] = 1'b1;
    end
    ch_busy = busy_pad[NUM_CH-1:0];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .PERIOD_W(PERIOD_W)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .base_tick    (base_tick),
      .load_now     (load_pad[i]),
      .new_enable   (cfg.cfg_enable),
      .load_at_wrap (ch_busy[i]),
      .new_period   (new_period),
`ifdef TICK_SCHED_SYNC_EN
      .sync_clr     (sync_req),
`endif
      .wrap         (wrap_v[i]),
      .active       (active_v[i]),
      .tick         (ch_tick[i]),
      .out          (ch_out[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench: stimulus queues expected channel ticks, a monitor pops them as ticks appear.
module tb_tick_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tick_scheduler_if #(.NUM_CH(4), .PERIOD_W(16)) bus ();
  tick_scheduler_if #(.NUM_CH(3), .PERIOD_W(16)) bus3 ();

  logic       base_tick, base_tick3;
  logic [3:0] ch_tick, ch_out, ch_busy;
  logic [2:0] ch_tick3, ch_out3, ch_busy3;
`ifdef TICK_SCHED_SYNC_EN
  logic sync_req = 1'b0;
`endif

  tick_scheduler #(.FREQ_IN(100), .TICK_FREQ(10), .NUM_CH(4), .PERIOD_W(16)) u_dut (
    .clk       (clk),
    .reset     (rst),
`ifdef TICK_SCHED_SYNC_EN
    .sync_req  (sync_req),
`endif
    .cfg       (bus),
    .base_tick (base_tick),
    .ch_tick   (ch_tick),
    .ch_out    (ch_out),
    .ch_busy   (ch_busy)
  );

  tick_scheduler #(.FREQ_IN(100), .TICK_FREQ(10), .NUM_CH(3), .PERIOD_W(16)) u_dut3 (
    .clk       (clk),
    .reset     (rst),
`ifdef TICK_SCHED_SYNC_EN
    .sync_req  (sync_req),
`endif
    .cfg       (bus3),
    .base_tick (base_tick3),
    .ch_tick   (ch_tick3),
    .ch_out    (ch_out3),
    .ch_busy   (ch_busy3)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        out;
  } ev_t;

  ev_t exp_q [4][$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  bit  armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      cyc   <= 0;
      armed <= 1'b1;
    end else begin
      cyc <= cyc + 1;
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void expect_tick(input int ch, input int c, input logic o);
    ev_t e;
    e.cyc = 32'(c);
    e.out = o;
    exp_q[ch].push_back(e);
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (armed) begin
      check("base_tick", 32'(base_tick), 32'((cyc % 10) == 9));
      for (int i = 0; i < 4; i++) begin
        if (ch_tick[i]) begin
          if (exp_q[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_tick: ch%0d ticked at cyc %0d, want no tick", i, cyc);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("tick_cyc_ch%0d", i), 32'(cyc), e.cyc);
            check($sformatf("tick_out_ch%0d", i), 32'(ch_out[i]), 32'(e.out));
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic en, input logic [15:0] p,
                           input int want_c);
    int n;
    n = 0;
    wait_cyc(want_c);
    bus.cfg_valid  = 1'b1;
    bus.cfg_ch     = ch;
    bus.cfg_enable = en;
    bus.cfg_period = p;
    while (!bus.cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("xfer_cycle", 32'(cyc), 32'(want_c));
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cfg_valid   = 1'b0;
    bus.cfg_ch      = '0;
    bus.cfg_enable  = 1'b0;
    bus.cfg_period  = '0;
    bus3.cfg_valid  = 1'b0;
    bus3.cfg_ch     = '0;
    bus3.cfg_enable = 1'b0;
    bus3.cfg_period = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ch_tick", 32'(ch_tick), 32'h0);
    check("rst_ch_out", 32'(ch_out), 32'h0);
    check("rst_ch_busy", 32'(ch_busy), 32'h0);
    check("rst_ready", 32'(bus.cfg_ready), 32'h1);
    check("rst_err", 32'(bus.cfg_err), 32'h0);
    check("rst_base_tick3", 32'(base_tick3), 32'h0);

    // Out-of-range channel index on the 3-channel instance.
    wait_cyc(5);
    bus3.cfg_valid  = 1'b1;
    bus3.cfg_ch     = 2'd3;
    bus3.cfg_enable = 1'b1;
    bus3.cfg_period = 16'd2;
    check("err_ready_before", 32'(bus3.cfg_ready), 32'h1);
    @(negedge clk);
    bus3.cfg_valid = 1'b0;
    check("err_pulse", 32'(bus3.cfg_err), 32'h1);
    check("err_ready_after", 32'(bus3.cfg_ready), 32'h1);
    @(negedge clk);
    check("err_single_cycle", 32'(bus3.cfg_err), 32'h0);
    check("err_no_state", 32'({ch_out3, ch_tick3, ch_busy3}), 32'h0);

    cfg_write(2'd0, 1'b1, 16'd3, 20);
    expect_tick(0, 50, 1'b1);
    expect_tick(0, 80, 1'b0);
    expect_tick(0, 110, 1'b1);
    check("en_ch0_out", 32'(ch_out), 32'h0);
    check("en_ch0_ready", 32'(bus.cfg_ready), 32'h1);

    cfg_write(2'd1, 1'b1, 16'd2, 23);
    expect_tick(1, 40, 1'b1);
    expect_tick(1, 60, 1'b0);
    expect_tick(1, 80, 1'b1);
    expect_tick(1, 130, 1'b0);
    expect_tick(1, 180, 1'b1);

    cfg_write(2'd1, 1'b1, 16'd5, 65);
    check("hold_ready_start", 32'(bus.cfg_ready), 32'h0);
    check("hold_busy_start", 32'(ch_busy), 32'h2);
    wait_cyc(79);
    check("hold_ready_end", 32'(bus.cfg_ready), 32'h0);
    check("hold_busy_end", 32'(ch_busy), 32'h2);
    wait_cyc(80);
    check("hold_ready_release", 32'(bus.cfg_ready), 32'h1);
    check("hold_busy_release", 32'(ch_busy), 32'h0);

    wait_cyc(115);
    check("dis_out_before", 32'(ch_out[0]), 32'h1);
    cfg_write(2'd0, 1'b0, 16'd3, 115);
    check("dis_out_after", 32'(ch_out[0]), 32'h0);

    cfg_write(2'd0, 1'b1, 16'd1, 125);
    expect_tick(0, 130, 1'b1);
    expect_tick(0, 140, 1'b0);
    expect_tick(0, 150, 1'b1);
    expect_tick(0, 160, 1'b0);

    cfg_write(2'd0, 1'b1, 16'd0, 165);
    wait_cyc(171);
    check("p0_out", 32'(ch_out[0]), 32'h0);

    cfg_write(2'd1, 1'b1, 16'd7, 185);
    check("hold2_ready", 32'(bus.cfg_ready), 32'h0);
    check("hold2_busy", 32'(ch_busy), 32'h2);
    check("pre_rst_ch_out", 32'(ch_out), 32'h2);
    check("main_err_quiet", 32'(bus.cfg_err), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drained_ch%0d", i), 32'(exp_q[i].size()), 32'h0);
    end

    wait_cyc(188);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_ch_out", 32'(ch_out), 32'h0);
    check("rst2_ch_tick", 32'(ch_tick), 32'h0);
    check("rst2_busy", 32'(ch_busy), 32'h0);
    check("rst2_ready", 32'(bus.cfg_ready), 32'h1);
    wait_cyc(60);
    check("rst2_idle_ready", 32'(bus.cfg_ready), 32'h1);
    check("rst2_idle_out", 32'(ch_out), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
